// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame checker.
// Holds the parity_mode encoding and the receiver FSM state type.
package uart_rx_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a received data word (purely combinational).
// Ports:
//   data    - received data bits
//   mode    - parity mode (none / even / odd / mark)
//   par_bit - parity bit the line should carry; 0 in none mode
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            mode,
    output logic                  par_bit
);
    import uart_rx_pkg::*;

    always_comb begin
        par_bit = 1'b0;
        case (mode)
            PAR_EVEN: par_bit = ^data;
            PAR_ODD:  par_bit = ~(^data);
            PAR_MARK: par_bit = 1'b1;
            default:  par_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive framer and checker. Consumes mid-bit samples from an
// oversampler (one bit per bit_valid strobe), assembles the data word
// LSB first, checks parity and stop bits, and presents the frame with a
// one-cycle data_valid pulse on the cycle after the final stop strobe.
// Ports:
//   rx_clk, rst          - clock, synchronous active-high reset
//   bit_valid            - strobe qualifying sampled_bit
//   sampled_bit          - line sample
//   parity_mode          - 00 none, 01 even, 10 odd, 11 mark
//   p_data               - last frame data
//   data_valid           - frame-complete pulse
//   parity_error         - parity flag of last frame
//   stop_error           - stop-bit flag of last frame
//   busy                 - FSM outside IDLE
//   par_err_cnt,
//   stop_err_cnt         - saturating error counters, only when
//                          UART_RX_ERR_CNT_EN is defined
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for a start bit (sample 0)
// ST_DATA   | shifting in DATA_WIDTH data bits
// ST_PARITY | checking the parity bit (mode latched at start)
// ST_STOP   | consuming STOP_BITS stop bits, then deliver
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  rx_clk,
    input  logic                  rst,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic [1:0]            parity_mode,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
`endif
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rx_state_t             state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            mode_q, mode_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  serr_pend_q, serr_pend_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic                  exp_par;
    logic                  last_stop;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
        .data    (shift_q),
        .mode    (mode_q),
        .par_bit (exp_par)
    );

    // STOP_BITS is 1 or 2, so a single bit tracks which stop bit is current.
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] par_err_cnt_q, par_err_cnt_d;
    logic [CNT_WIDTH-1:0] stop_err_cnt_q, stop_err_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        mode_d         = mode_q;
        stop_cnt_d     = stop_cnt_q;
        perr_pend_d    = perr_pend_q;
        serr_pend_d    = serr_pend_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;

        if (bit_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sampled_bit) begin
                        state_d     = ST_DATA;
                        mode_d      = parity_mode;
                        bit_cnt_d   = '0;
                        stop_cnt_d  = 1'b0;
                        perr_pend_d = 1'b0;
                        serr_pend_d = 1'b0;
                        shift_d     = '0;
                    end
                end
                ST_DATA: begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == BCW'(i)) shift_d[i] = sampled_bit;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        state_d = (mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    perr_pend_d = sampled_bit ^ exp_par;
                    state_d     = ST_STOP;
                end
                ST_STOP: begin
                    if (!sampled_bit) serr_pend_d = 1'b1;
                    if (last_stop) begin
                        state_d        = ST_IDLE;
                        data_valid_d   = 1'b1;
                        p_data_d       = shift_q;
                        parity_error_d = perr_pend_q;
                        stop_error_d   = serr_pend_q | ~sampled_bit;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Counters move on the same edge as the flags, so the new count is
    // visible alongside data_valid.
    always_comb begin
        par_err_cnt_d  = par_err_cnt_q;
        stop_err_cnt_d = stop_err_cnt_q;
        if (data_valid_d) begin
            if (parity_error_d && !(&par_err_cnt_q)) par_err_cnt_d = par_err_cnt_q + 1'b1;
            if (stop_error_d && !(&stop_err_cnt_q)) stop_err_cnt_d = stop_err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            par_err_cnt_q  <= '0;
            stop_err_cnt_q <= '0;
        end else begin
            par_err_cnt_q  <= par_err_cnt_d;
            stop_err_cnt_q <= stop_err_cnt_d;
        end
    end

    assign par_err_cnt  = par_err_cnt_q;
    assign stop_err_cnt = stop_err_cnt_q;
`endif

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            mode_q         <= PAR_NONE;
            stop_cnt_q     <= 1'b0;
            perr_pend_q    <= 1'b0;
            serr_pend_q    <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            mode_q         <= mode_d;
            stop_cnt_q     <= stop_cnt_d;
            perr_pend_q    <= perr_pend_d;
            serr_pend_q    <= serr_pend_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench for uart_rx_frame_check (DATA_WIDTH=8, STOP_BITS=1).
// Counter checks are compiled in when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_frame_check;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int SB = 1;
    localparam int CW = 8;

    logic          rx_clk;
    logic          rst;
    logic          bit_valid;
    logic          sampled_bit;
    logic [1:0]    parity_mode;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stop_err_cnt;
    logic [CW-1:0] mdl_pcnt;
    logic [CW-1:0] mdl_scnt;
`endif

    uart_rx_frame_check #(.DATA_WIDTH(DW), .STOP_BITS(SB), .CNT_WIDTH(CW)) dut (
        .rx_clk       (rx_clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .sampled_bit  (sampled_bit),
        .parity_mode  (parity_mode),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .par_err_cnt  (par_err_cnt),
        .stop_err_cnt (stop_err_cnt)
`endif
    );

    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic       par;
        logic [1:0] stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic final_stop;
    logic dv_seen;
    logic start_dv;
    logic mon_exp_dv;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; drives one strobed bit for one cycle.
    task automatic send_bit(input logic b, input logic fin, input int gap);
        dv_seen     = data_valid;
        bit_valid   = 1'b1;
        sampled_bit = b;
        final_stop  = fin;
        @(negedge rx_clk);
        bit_valid   = 1'b0;
        sampled_bit = 1'b1;
        final_stop  = 1'b0;
        repeat (gap) @(negedge rx_clk);
    endtask

    task automatic send_frame(input logic [1:0] mode, input logic [1:0] mode_mid,
                              input logic [7:0] data, input logic par,
                              input logic [1:0] stop, input int gap, input exp_t e);
        parity_mode = mode;
        send_bit(1'b0, 1'b0, gap);
        start_dv = dv_seen;
        parity_mode = mode_mid;
        for (int i = 0; i < DW; i++) send_bit(data[i], 1'b0, gap);
        if (mode != PAR_NONE) send_bit(par, 1'b0, gap);
        for (int s = 0; s < SB; s++) begin
            if (s == SB - 1) sb_q.push_back(e);
            send_bit(stop[s], (s == SB - 1), gap);
        end
    endtask

    // Monitor: data_valid must appear exactly one cycle after the final stop
    // strobe, and each pulse is checked against the scoreboard.
    always @(posedge rx_clk) begin
        mon_exp_dv = bit_valid && final_stop && !rst;
`ifdef UART_RX_ERR_CNT_EN
        if (rst) begin
            mdl_pcnt = '0;
            mdl_scnt = '0;
        end
`endif
        #1;
        if (mon_exp_dv || data_valid) check("dv_timing", 32'(data_valid), 32'(mon_exp_dv));
        if (data_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_dv", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("p_data", 32'(p_data), 32'(mon_e.d));
                check("parity_error", 32'(parity_error), 32'(mon_e.pe));
                check("stop_error", 32'(stop_error), 32'(mon_e.se));
`ifdef UART_RX_ERR_CNT_EN
                if (mon_e.pe && mdl_pcnt != '1) mdl_pcnt = mdl_pcnt + 1'b1;
                if (mon_e.se && mdl_scnt != '1) mdl_scnt = mdl_scnt + 1'b1;
                check("par_err_cnt", 32'(par_err_cnt), 32'(mdl_pcnt));
                check("stop_err_cnt", 32'(stop_err_cnt), 32'(mdl_scnt));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] d55;

    initial begin
        vecs[0] = '{PAR_EVEN, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{PAR_ODD,  8'h03, 1'b0, 2'b11, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{PAR_NONE, 8'h7E, 1'b0, 2'b10, 8'h7E, 1'b0, 1'b1};
        vecs[3] = '{PAR_EVEN, 8'h01, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{PAR_EVEN, 8'h01, 1'b0, 2'b11, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{PAR_ODD,  8'h00, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{PAR_MARK, 8'h5A, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{PAR_MARK, 8'h5A, 1'b0, 2'b10, 8'h5A, 1'b1, 1'b1};
        vecs[8] = '{PAR_NONE, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{PAR_ODD,  8'h80, 1'b0, 2'b11, 8'h80, 1'b0, 1'b0};

        rst = 1'b1; bit_valid = 1'b0; sampled_bit = 1'b1;
        parity_mode = PAR_NONE; final_stop = 1'b0;
        repeat (3) @(negedge rx_clk);
        check("rst_p_data", 32'(p_data), 32'(0));
        check("rst_data_valid", 32'(data_valid), 32'(0));
        check("rst_parity_error", 32'(parity_error), 32'(0));
        check("rst_stop_error", 32'(stop_error), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(negedge rx_clk);

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].mode, vecs[v].mode, vecs[v].data, vecs[v].par, vecs[v].stop, 1,
                       '{vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_serr});
            repeat (2) @(negedge rx_clk);
            check("busy_after_frame", 32'(busy), 32'(0));
        end

        // Mode switched to none after the start bit: parity bit still expected.
        send_frame(PAR_EVEN, PAR_NONE, 8'h01, 1'b1, 2'b11, 1, '{8'h01, 1'b0, 1'b0});
        repeat (2) @(negedge rx_clk);

        // Reset after four data bits discards the frame.
        d55 = 8'h55;
        parity_mode = PAR_EVEN;
        send_bit(1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(d55[i], 1'b0, 1);
        check("busy_mid_frame", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge rx_clk);
        check("busy_after_rst", 32'(busy), 32'(0));
        check("p_data_after_rst", 32'(p_data), 32'(0));
        rst = 1'b0;
        @(negedge rx_clk);
        send_frame(PAR_EVEN, PAR_EVEN, 8'h55, 1'b0, 2'b11, 1, '{8'h55, 1'b0, 1'b0});
        repeat (2) @(negedge rx_clk);

        // Back-to-back: second start strobe lands in the data_valid cycle.
        send_frame(PAR_EVEN, PAR_EVEN, 8'h12, 1'b0, 2'b11, 0, '{8'h12, 1'b0, 1'b0});
        send_frame(PAR_EVEN, PAR_EVEN, 8'h34, 1'b1, 2'b11, 0, '{8'h34, 1'b0, 1'b0});
        check("b2b_start_in_dv_cycle", 32'(start_dv), 32'(1));
        repeat (2) @(negedge rx_clk);

`ifdef UART_RX_ERR_CNT_EN
        rst = 1'b1;
        @(negedge rx_clk);
        rst = 1'b0;
        check("cnt_after_rst", 32'(par_err_cnt), 32'(0));
        for (int k = 0; k < 256; k++) begin
            send_frame(PAR_ODD, PAR_ODD, 8'h03, 1'b0, 2'b11, 0, '{8'h03, 1'b1, 1'b0});
        end
        repeat (2) @(negedge rx_clk);
        check("par_err_cnt_saturated", 32'(par_err_cnt), 32'(8'hFF));
        check("stop_err_cnt_untouched", 32'(stop_err_cnt), 32'(0));
`endif

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge rx_clk);
        check("sb_drain", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
